// File: rtl/bp_update_sched.sv
// bp_update_sched: 2-bit branch predictor table scheduler.
// Serialises lookups, queued updates and table init onto one table port.
//
// Ports:
//   clk, reset (async, active-low)
//   lookup_valid/lookup_index/lookup_ready : lookup request handshake
//   pred_valid/prediction                  : prediction response
//   upd_valid/upd_index/branch_outcome/upd_ready : resolved-branch update
//   tbl_en/tbl_we/tbl_addr/tbl_wdata/tbl_rdata   : external table port
//   init_done                              : table initialisation complete
//   lookup_cnt/upd_cnt                     : statistics counters
//
// Optional feature macro: BP_STATS_EN (statistics counters).
module bp_update_sched #(
  parameter int IDX_W  = 4,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_index,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             prediction,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             branch_outcome,
  output logic             upd_ready,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata,
  output logic             init_done,
  output logic [15:0]      lookup_cnt,
  output logic [15:0]      upd_cnt
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [IDX_W-1:0] LAST_ADDR = {IDX_W{1'b1}};
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    UPD_RD,
    UPD_WR
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_init_addr;
  logic             r_init_done;
  logic             r_pred_valid;

  // Update queue entries hold {index, outcome}.
  logic [IDX_W:0]   r_q_mem [QDEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;

  // Update currently being applied (popped on entry to UPD_RD).
  logic [IDX_W-1:0] r_cur_idx;
  logic             r_cur_out;

  logic             w_full;
  logic             w_empty;
  logic             w_idle;
  logic             w_push;
  logic             w_pop;
  logic             w_lk_acc;
  logic [1:0]       w_next_ctr;

  logic             w_en;
  logic             w_we;
  logic [IDX_W-1:0] w_addr;
  logic [1:0]       w_wdata;

  assign w_full  = (r_cnt == FULL_CNT);
  assign w_empty = (r_cnt == '0);
  assign w_idle  = (r_state == IDLE);

  assign lookup_ready = w_idle & ~w_full;
  assign w_lk_acc     = lookup_ready & lookup_valid;

  // Occupancy is registered, so a pop in a full cycle never frees a slot
  // for an enqueue in that same cycle.
  assign upd_ready = ~w_full;
  assign w_push    = upd_valid & ~w_full;

  // Full queue beats lookups; otherwise lookups beat draining.
  assign w_pop = w_idle & (w_full | (~lookup_valid & ~w_empty));

  // Saturating 2-bit counter step.
  always_comb begin
    w_next_ctr = tbl_rdata;
    if (r_cur_out) begin
      if (tbl_rdata != 2'b11) begin
        w_next_ctr = tbl_rdata + 2'd1;
      end
    end else begin
      if (tbl_rdata != 2'b00) begin
        w_next_ctr = tbl_rdata - 2'd1;
      end
    end
  end

  // Single table port: the state owns the port each cycle.
  always_comb begin
    w_en    = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      INIT: begin
        w_en    = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_init_addr;
        w_wdata = 2'b01;
      end
      IDLE: begin
        if (w_lk_acc) begin
          w_en   = 1'b1;
          w_addr = lookup_index;
        end
      end
      UPD_RD: begin
        w_en   = 1'b1;
        w_addr = r_cur_idx;
      end
      UPD_WR: begin
        w_en    = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_cur_idx;
        w_wdata = w_next_ctr;
      end
      default: begin
        w_en = 1'b0;
      end
    endcase
  end

  // Strobes are held off while reset is asserted.
  assign tbl_en    = w_en & reset;
  assign tbl_we    = w_we & reset;
  assign tbl_addr  = w_addr;
  assign tbl_wdata = w_wdata;

  assign pred_valid = r_pred_valid;
  assign prediction = r_pred_valid & tbl_rdata[1];
  assign init_done  = r_init_done;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_mem[r_wp] <= {upd_index, branch_outcome};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= INIT;
      r_init_addr  <= '0;
      r_init_done  <= 1'b0;
      r_pred_valid <= 1'b0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_cur_idx    <= '0;
      r_cur_out    <= 1'b0;
    end else begin
      r_pred_valid <= w_lk_acc;
      case (r_state)
        INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (r_init_addr == LAST_ADDR) begin
            r_state     <= IDLE;
            r_init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (w_pop) begin
            r_state <= UPD_RD;
          end
        end
        UPD_RD: begin
          r_state <= UPD_WR;
        end
        UPD_WR: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= INIT;
        end
      endcase
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp      <= r_rp + 1'b1;
        r_cur_idx <= r_q_mem[r_rp][IDX_W:1];
        r_cur_out <= r_q_mem[r_rp][0];
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] r_lk_cnt;
  logic [15:0] r_upd_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lk_cnt  <= '0;
      r_upd_cnt <= '0;
    end else begin
      if (w_lk_acc && (r_lk_cnt != 16'hFFFF)) begin
        r_lk_cnt <= r_lk_cnt + 16'd1;
      end
      if ((r_state == UPD_WR) && (r_upd_cnt != 16'hFFFF)) begin
        r_upd_cnt <= r_upd_cnt + 16'd1;
      end
    end
  end

  assign lookup_cnt = r_lk_cnt;
  assign upd_cnt    = r_upd_cnt;
`else
  assign lookup_cnt = '0;
  assign upd_cnt    = '0;
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: scoreboard bench for bp_update_sched.
// Expected predictions and table writes are queued and checked by monitors.
module tb_bp_update_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lookup_valid = 1'b0;
  logic [3:0] lookup_index = '0;
  logic       lookup_ready;
  logic       pred_valid;
  logic       prediction;
  logic       upd_valid = 1'b0;
  logic [3:0] upd_index = '0;
  logic       branch_outcome = 1'b0;
  logic       upd_ready;
  logic       tbl_en;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [1:0] tbl_wdata;
  logic [1:0] tbl_rdata = '0;
  logic       init_done;
  logic [15:0] lookup_cnt;
  logic [15:0] upd_cnt;

  int total = 0;
  int bad = 0;
  int acc_lk = 0;
  int n_upd = 0;
  int lk_exp = 0;
  int pq[$];
  int wq[$];
  logic [1:0] mem [16];

  bp_update_sched #(.IDX_W(4), .QDEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index),
    .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .prediction(prediction),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .branch_outcome(branch_outcome), .upd_ready(upd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
    .init_done(init_done),
    .lookup_cnt(lookup_cnt), .upd_cnt(upd_cnt)
  );

  always #5 clk = ~clk;

  // Table memory model.
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else tbl_rdata <= mem[tbl_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Accepted lookups push their expected prediction.
  always @(negedge clk) begin
    if (reset && lookup_valid && lookup_ready) begin
      pq.push_back(lk_exp);
      acc_lk++;
    end
  end

  // Prediction monitor.
  always @(negedge clk) begin
    if (pred_valid) begin
      if (pq.size() == 0) chk("unexpected_pred", 1, 0);
      else chk("prediction", int'(prediction), pq.pop_front());
    end
  end

  // Table write monitor: value is addr*4+data.
  always @(negedge clk) begin
    if (tbl_en && tbl_we) begin
      if (wq.size() == 0) chk("unexpected_write", tbl_addr * 4 + tbl_wdata, -1);
      else chk("table_write", tbl_addr * 4 + tbl_wdata, wq.pop_front());
    end
  end

  task automatic push_init();
    for (int i = 0; i < 16; i++) wq.push_back(i * 4 + 1);
  endtask

  task automatic lookup(input int idx, input int exp);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    lookup_valid = 1'b1;
    lookup_index = 4'(idx);
    lk_exp = exp;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lookup_ready) begin ok = 1; break; end
    end
    if (!ok) chk("lookup_timeout", 0, 1);
    @(posedge clk); #1;
    lookup_valid = 1'b0;
  endtask

  // Leaves upd_valid high; caller ends a burst with upd_off.
  task automatic upd(input int idx, input int outc, input int expw);
    bit ok;
    ok = 0;
    wq.push_back(idx * 4 + expw);
    n_upd++;
    @(posedge clk); #1;
    upd_valid = 1'b1;
    upd_index = 4'(idx);
    branch_outcome = outc[0];
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (upd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("upd_timeout", 0, 1);
  endtask

  task automatic upd_off();
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (init_done) begin n = i; break; end
    end
    chk(nm, n, 16);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    push_init();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_pred_valid", int'(pred_valid), 0);
    chk("rst_prediction", int'(prediction), 0);
    chk("rst_tbl_en", int'(tbl_en), 0);
    chk("rst_tbl_we", int'(tbl_we), 0);
    chk("rst_lookup_cnt", int'(lookup_cnt), 0);
    chk("rst_upd_cnt", int'(upd_cnt), 0);

    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("init_upd_ready", int'(upd_ready), 1);
    chk("init_lookup_ready", int'(lookup_ready), 0);
    wait_init("init_cycles");
    chk("idle_lookup_ready", int'(lookup_ready), 1);
    chk("wq_after_init", wq.size(), 0);

    lookup(3, 0);

    upd(4, 1, 2);
    upd(4, 1, 3);
    upd_off();
    repeat (12) @(posedge clk);
    lookup(4, 1);
    upd(4, 1, 3);
    upd_off();
    repeat (8) @(posedge clk);
    lookup(4, 1);

    upd(3, 1, 2);
    upd(3, 0, 1);
    upd(3, 1, 2);
    upd(3, 0, 1);
    upd_off();
    repeat (16) @(posedge clk);
    lookup(3, 0);

    for (int i = 0; i < 4; i++) upd(5, 0, 0);
    upd_off();
    repeat (16) @(posedge clk);
    lookup(5, 0);
    chk("wq_after_basic", wq.size(), 0);

    // Fill the queue while lookups keep the FSM busy in IDLE.
    @(posedge clk); #1;
    lookup_valid = 1'b1;
    lookup_index = 4'd6;
    lk_exp = 0;
    upd(7, 1, 2);
    upd(8, 0, 0);
    upd(9, 1, 2);
    upd(10, 1, 2);
    upd_off();
    @(negedge clk);
    chk("full_upd_ready", int'(upd_ready), 0);
    chk("full_lookup_ready", int'(lookup_ready), 0);
    n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lookup_ready) break;
      n++;
    end
    chk("stall_cycles", n, 3);
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    repeat (30) @(posedge clk);
    chk("wq_after_drain", wq.size(), 0);
    chk("pq_after_drain", pq.size(), 0);
    lookup(8, 0);
    lookup(9, 1);
`ifdef BP_STATS_EN
    @(negedge clk);
    chk("stat_lookup_cnt", int'(lookup_cnt), acc_lk);
    chk("stat_upd_cnt", int'(upd_cnt), n_upd);
`else
    @(negedge clk);
    chk("nostat_lookup_cnt", int'(lookup_cnt), 0);
    chk("nostat_upd_cnt", int'(upd_cnt), 0);
`endif

    // Queue three updates, then reset before any is applied.
    @(posedge clk); #1;
    lookup_valid = 1'b1;
    lookup_index = 4'd6;
    lk_exp = 0;
    for (int i = 12; i < 15; i++) begin
      @(posedge clk); #1;
      upd_valid = 1'b1;
      upd_index = 4'(i);
      branch_outcome = 1'b1;
      @(negedge clk);
      chk("q3_upd_ready", int'(upd_ready), 1);
    end
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    upd_valid = 1'b0;
    @(negedge clk);
    push_init();
    #1;
    reset = 1'b0;
    #1;
    chk("rst2_init_done", int'(init_done), 0);
    chk("rst2_upd_ready", int'(upd_ready), 1);
    chk("rst2_tbl_en", int'(tbl_en), 0);
    chk("rst2_lookup_cnt", int'(lookup_cnt), 0);
    chk("rst2_upd_cnt", int'(upd_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_init("reinit_cycles");
    repeat (20) @(posedge clk);
    chk("wq_after_reinit", wq.size(), 0);
    lookup(12, 0);
    lookup(13, 0);
    repeat (4) @(posedge clk);
    chk("pq_final", pq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
